rr_merge_2to1: RTL and testbench
================================

// Module: rr_merge_2to1
// PURPOSE
//  Recombines the two output streams of a 1:2 demux stage (Y0 path, Y1 path) into one stream.
//  Each input is a valid/ready stream; the block picks between them by fair round-robin.
//  It holds one accepted word in a single output register stage, tagged with its source index.
//  It keeps a saturating accept counter per input for debug.
// PARAMETERS
//  WIDTH   8   data width of each input and of the output
//  CNT_W   8   width of each per-input accept counter
// PORTS
//  clk        in   1        single clock; all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in0_valid  in   1        input 0 (demux Y0 path) word available
//  in0_data   in   WIDTH    input 0 data
//  in0_ready  out  1        input 0 word accepted this cycle when in0_valid & in0_ready
//  in1_valid  in   1        input 1 (demux Y1 path) word available
//  in1_data   in   WIDTH    input 1 data
//  in1_ready  out  1        input 1 word accepted this cycle when in1_valid & in1_ready
//  out_valid  out  1        output register holds a word
//  out_data   out  WIDTH    registered output data
//  out_src    out  1        source of out_data (0 = in0, 1 = in1)
//  out_ready  in   1        downstream takes the word when out_valid & out_ready
//  cnt0       out  CNT_W    number of words accepted from in0, saturating
//  cnt1       out  CNT_W    number of words accepted from in1, saturating
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_src=0, cnt0=cnt1=0, prio=0.
//   A word held at reset is dropped. in0_ready and in1_ready are 0 while rst=1.
//  State: 1-bit prio, the input that wins a tie; output register {out_valid, out_data, out_src}.
//  load_en = !out_valid | out_ready. It is combinational and lets the register refill in the
//   same cycle it drains, so throughput is 1 word/cycle.
//  Grant g (combinational):
//   - only in0_valid -> g=0
//   - only in1_valid -> g=1
//   - both valid -> g=prio
//   - neither valid -> no grant
//  inK_ready = load_en & !rst & (g==K) & inK_valid. At most one input is accepted per cycle.
//  inK_ready may depend on valids and out_ready. Upstream valid must not depend on ready.
//  On accept from K: out_data<=inK_data, out_src<=K, out_valid<=1, prio<=~K,
//   cntK<=cntK+1 unless cntK==all-ones (then it holds).
//  If out_valid & out_ready and nothing is accepted: out_valid<=0; out_data/out_src hold.
//  Stall (out_valid & !out_ready): out_data/out_src stay stable; both readys are 0.
//  Latency: an accepted word appears on out_* the next cycle. No reordering within one input.
//  If an input stays valid while the other is continuously valid, it is granted within
//   2 accepts (no starvation).
//  prio changes only on an accept. An idle cycle leaves prio unchanged.
// TESTING
//  1 Reset: drive rst=1 with both inputs valid -> out_valid=0, readys=0, cnt0=cnt1=0.
//    Release rst, out_ready=1 -> in0 is granted first (prio=0).
//  2 Alternation: in0_valid=in1_valid=1 continuously with data 0xA0.. / 0xB0.., out_ready=1
//    -> out_src toggles 0,1,0,1 each cycle; one word per cycle; cnt0 and cnt1 rise together.
//  3 Single source: only in1_valid for 5 words 0x11..0x15 -> out_data 0x11..0x15 in order,
//    out_src=1, 1-cycle latency, cnt1=5, cnt0=0.
//  4 Backpressure: out_ready=0 for 4 cycles with a word held -> out_valid=1 and out_data stable,
//    both readys=0. Raise out_ready -> the next word loads in the same cycle the held word drains.
//  5 Saturation: with CNT_W=3, accept 10 words from in0 -> cnt0 stops at 7 and holds;
//    data flow is unaffected.
//  6 Mid-operation reset: assert rst for 1 cycle while a word is stalled -> out_valid=0 next
//    cycle, counters 0, prio 0. The held word never appears on out_*.

Source files
------------

// File: rtl/rr_merge_2to1.sv
// rr_merge_2to1: fair round-robin merge of two valid/ready streams
// into one registered output stage with source tag and accept counters.
module rr_merge_2to1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic prio;
  logic gnt;
  logic load_en;
  logic acc0;
  logic acc1;

  // Register may refill in the same cycle it drains.
  assign load_en = !out_valid | out_ready;

  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (in0_valid & in1_valid):  gnt = prio;
      (!in0_valid & in1_valid): gnt = 1'b1;
      default:                  gnt = 1'b0;
    endcase
  end

  assign acc0 = load_en & !rst & !gnt & in0_valid;
  assign acc1 = load_en & !rst & gnt & in1_valid;

  assign in0_ready = acc0;
  assign in1_ready = acc1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      prio      <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else if (acc0) begin
      out_valid <= 1'b1;
      out_data  <= in0_data;
      out_src   <= 1'b0;
      prio      <= 1'b1;
      if (cnt0 != {CNT_W{1'b1}})
        cnt0 <= cnt0 + CNT_W'(1);
    end else if (acc1) begin
      out_valid <= 1'b1;
      out_data  <= in1_data;
      out_src   <= 1'b1;
      prio      <= 1'b0;
      if (cnt1 != {CNT_W{1'b1}})
        cnt1 <= cnt1 + CNT_W'(1);
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_merge_2to1.sv
// tb_rr_merge_2to1: directed vector table plus hand sequences
// for the round-robin 2:1 merge.
module tb_rr_merge_2to1;

  logic       clk;
  logic       rst;
  logic       in0_valid;
  logic [7:0] in0_data;
  logic       in1_valid;
  logic [7:0] in1_data;
  logic       out_ready;

  logic       in0_ready;
  logic       in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  logic       s_in0_ready;
  logic       s_in1_ready;
  logic       s_out_valid;
  logic [7:0] s_out_data;
  logic       s_out_src;
  logic [2:0] s_cnt0;
  logic [2:0] s_cnt1;

  int errors = 0;
  int checks = 0;

  rr_merge_2to1 dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  rr_merge_2to1 #(.WIDTH(8), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_ready(s_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_ready(s_in1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data),
    .out_src(s_out_src), .out_ready(out_ready),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
    logic       os;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic v0, logic [7:0] d0,
    logic v1, logic [7:0] d1, logic ordy,
    logic r0, logic r1, logic ov,
    logic [7:0] od, logic os,
    logic [7:0] c0, logic [7:0] c1);
    vec_t v;
    v.rst = r;   v.v0 = v0;  v.d0 = d0;
    v.v1 = v1;   v.d1 = d1;  v.ordy = ordy;
    v.r0 = r0;   v.r1 = r1;  v.ov = ov;
    v.od = od;   v.os = os;
    v.c0 = c0;   v.c1 = c1;
    return v;
  endfunction

  task automatic chk(string name, int idx,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h",
               name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic v0, logic [7:0] d0,
                       logic v1, logic [7:0] d1, logic ordy);
    rst = r;
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = ordy;
  endtask

  task automatic apply(vec_t v, int idx);
    drive(v.rst, v.v0, v.d0, v.v1, v.d1, v.ordy);
    #1;
    chk("in0_ready", idx, 32'(in0_ready), 32'(v.r0));
    chk("in1_ready", idx, 32'(in1_ready), 32'(v.r1));
    @(posedge clk);
    #1;
    chk("out_valid", idx, 32'(out_valid), 32'(v.ov));
    chk("out_data", idx, 32'(out_data), 32'(v.od));
    chk("out_src", idx, 32'(out_src), 32'(v.os));
    chk("cnt0", idx, 32'(cnt0), 32'(v.c0));
    chk("cnt1", idx, 32'(cnt1), 32'(v.c1));
    chk("s_cnt0", idx, 32'(s_cnt0), 32'(v.c0[2:0]));
    chk("s_cnt1", idx, 32'(s_cnt1), 32'(v.c1[2:0]));
  endtask

  initial begin
    drive(1'b1, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
    // rst v0 d0 v1 d1 ordy | r0 r1 ov od os c0 c1
    tbl.push_back(mk(1,1,8'h01,1,8'h02,1, 0,0,0,8'h00,0,0,0));
    tbl.push_back(mk(1,1,8'h01,1,8'h02,1, 0,0,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,8'hA0,1,8'hB0,1, 1,0,1,8'hA0,0,1,0));
    tbl.push_back(mk(0,1,8'hA1,1,8'hB0,1, 0,1,1,8'hB0,1,1,1));
    tbl.push_back(mk(0,1,8'hA1,1,8'hB1,1, 1,0,1,8'hA1,0,2,1));
    tbl.push_back(mk(0,1,8'hA2,1,8'hB1,1, 0,1,1,8'hB1,1,2,2));
    tbl.push_back(mk(0,0,8'hA2,0,8'hB2,1, 0,0,0,8'hB1,1,2,2));
    tbl.push_back(mk(1,0,8'h00,0,8'h00,1, 0,0,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,8'h00,1,8'h11,1, 0,1,1,8'h11,1,0,1));
    tbl.push_back(mk(0,0,8'h00,1,8'h12,1, 0,1,1,8'h12,1,0,2));
    tbl.push_back(mk(0,0,8'h00,1,8'h13,1, 0,1,1,8'h13,1,0,3));
    tbl.push_back(mk(0,0,8'h00,1,8'h14,1, 0,1,1,8'h14,1,0,4));
    tbl.push_back(mk(0,0,8'h00,1,8'h15,1, 0,1,1,8'h15,1,0,5));
    tbl.push_back(mk(0,0,8'h00,0,8'h00,1, 0,0,0,8'h15,1,0,5));
    tbl.push_back(mk(0,1,8'hC0,0,8'h00,0, 1,0,1,8'hC0,0,1,5));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,1,8'hC1,1,8'hD0,0, 0,0,1,8'hC0,0,1,5));
    tbl.push_back(mk(0,1,8'hC1,1,8'hD0,1, 0,1,1,8'hD0,1,1,6));
    tbl.push_back(mk(0,1,8'hC1,1,8'hD1,1, 1,0,1,8'hC1,0,2,6));
    tbl.push_back(mk(0,0,8'h00,0,8'h00,0, 0,0,1,8'hC1,0,2,6));
    tbl.push_back(mk(0,0,8'h00,0,8'h00,1, 0,0,0,8'hC1,0,2,6));
    tbl.push_back(mk(0,1,8'hE0,0,8'h00,0, 1,0,1,8'hE0,0,3,6));
    tbl.push_back(mk(0,1,8'hE1,1,8'hF0,0, 0,0,1,8'hE0,0,3,6));
    // Reset while stalled: held E0 is dropped and prio returns to in0.
    tbl.push_back(mk(1,1,8'hE1,1,8'hF0,0, 0,0,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,8'hE2,1,8'hF1,1, 1,0,1,8'hE2,0,1,0));
    tbl.push_back(mk(0,0,8'h00,0,8'h00,1, 0,0,0,8'hE2,0,1,0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Saturation: CNT_W=3 instance stops at 7, data unaffected.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic [2:0] sc;
      d = 8'h30 + 8'(i);
      sc = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      drive(1'b0, 1'b1, d, 1'b0, 8'h00, 1'b1);
      #1;
      chk("sat_in0_ready", 100 + i, 32'(s_in0_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("sat_out_valid", 100 + i, 32'(s_out_valid), 32'd1);
      chk("sat_out_data", 100 + i, 32'(s_out_data), 32'(d));
      chk("sat_out_src", 100 + i, 32'(s_out_src), 32'd0);
      chk("sat_cnt0", 100 + i, 32'(s_cnt0), 32'(sc));
      chk("sat_cnt1", 100 + i, 32'(s_cnt1), 32'd0);
      chk("wide_cnt0", 100 + i, 32'(cnt0), 32'(i + 1));
    end

    // Saturated counter holds across a further idle cycle.
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("sat_hold", 200, 32'(s_cnt0), 32'd7);
    chk("sat_drain", 200, 32'(s_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
